rgb_led_ctrl: RTL
=================

RGB_LED_CTRL -- requirements
Module: rgb_led_ctrl

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 187, meaning clocks per PWM tick; legal range 1..65535.
REQ-002 The block SHALL have parameter BLINK_FRAMES, default 64, meaning frames per blink phase; legal range 1..255.
REQ-003 The block SHALL have port i_clk  input  1  system clock; single clock domain, all logic on the rising edge.
REQ-004 The block SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port i_wr  input  1  register write request.
REQ-006 The block SHALL have port i_addr  input  2  register select: 0=red duty, 1=green duty, 2=blue duty, 3=mode.
REQ-007 The block SHALL have port i_data  input  8  write data.
REQ-008 The block SHALL have port o_ready  output  1  write accepted this cycle when i_wr && o_ready.
REQ-009 The block SHALL have ports o_led_r, o_led_g, o_led_b  output  1 each  PWM drive for the RGB LED driver PWM inputs.
REQ-010 The block SHALL have port o_frame  output  1  one-cycle pulse at each PWM frame start.

Function
REQ-011 Prescaler SHALL count 0..PRESCALE-1 and wrap; tick = prescaler==PRESCALE-1; PRESCALE=1 ticks every cycle.
REQ-012 8-bit PWM counter SHALL increment on tick and wrap 255->0; frame boundary = tick && pwm_cnt==255.
REQ-013 o_frame SHALL be registered, high exactly on the cycle after each frame boundary, when pwm_cnt==0.
REQ-014 Accepted writes SHALL update shadow registers only; shadow duty[0..2] and mode[1:0] SHALL copy to active registers at each frame boundary.
REQ-015 o_ready SHALL be 0 on the frame-boundary cycle and 1 otherwise; a write presented then is not accepted and the requester holds i_wr.
REQ-016 Two accepted writes to the same address before a boundary: last value SHALL win.
REQ-017 Writes to mode SHALL use i_data[1:0]: 0=STATIC, 1=BLINK, 2=BREATHE, 3 treated as STATIC; i_data[7:2] ignored.
REQ-018 Sequencer states SHALL be S_STATIC, S_BLINK_ON, S_BLINK_OFF, S_RAMP_UP, S_RAMP_DOWN; transitions occur only at frame boundaries.
REQ-019 On a boundary where the committed mode differs from the current mode, the sequencer SHALL enter S_STATIC, S_BLINK_ON, or S_RAMP_UP; it SHALL clear the frame count and set env=0.
REQ-020 BLINK: each phase SHALL last BLINK_FRAMES frames, then toggle ON<->OFF with the frame count cleared.
REQ-021 BREATHE: 8-bit env SHALL increment by 1 per frame in S_RAMP_UP; at env==255 the sequencer SHALL go to S_RAMP_DOWN.
REQ-022 In S_RAMP_DOWN, env SHALL decrement by 1 per frame; at env==0 the sequencer SHALL go to S_RAMP_UP; env SHALL never wrap.
REQ-023 Effective duty eff SHALL be: S_STATIC and S_BLINK_ON = active duty; S_BLINK_OFF = 0; S_RAMP_UP and S_RAMP_DOWN = (duty*env)>>8, 16-bit product truncated to 8 bits.
REQ-024 Each LED output SHALL be registered as eff > pwm_cnt: duty 0 gives constant 0; duty 255 gives 255 high ticks of every 256.
REQ-025 Output latency SHALL be 1 clock from pwm_cnt/eff change to pin change.

Reset
REQ-026 While i_rst_n==0 at a clock edge, all counters, env, and shadow and active registers SHALL become 0, with state S_STATIC.
REQ-027 During reset, o_led_r/g/b=0, o_frame=0, and o_ready=1.
REQ-028 Reset asserted mid-frame or mid-ramp SHALL abort immediately; uncommitted shadow writes SHALL be lost.
REQ-029 After i_rst_n rises, the first tick SHALL occur PRESCALE cycles later.

Verification
REQ-030 Static duty test: PRESCALE=1, write R=64 -> after the next boundary, o_led_r high exactly 64 of each 256 cycles; G and B stay 0.
REQ-031 Shadow test: write G=200 mid-frame -> o_led_g unchanged until the boundary, then 200/256 high; a write held on the o_ready=0 cycle is accepted one cycle later.
REQ-032 Extremes test: duty 0 -> never high; duty 255 -> low exactly 1 cycle per frame at pwm_cnt==255 (+1 latency).
REQ-033 Blink test: BLINK_FRAMES=2, mode=1, B=255 -> pattern of 2 frames on, 2 frames off, repeating.
REQ-034 Breathe test: mode=2, R=255 -> env 0..255 over 255 frames; frame 128 has eff=127; then it descends to 0 and re-ascends without wrap.
REQ-035 Reset test: pulse i_rst_n low mid-ramp for 1 cycle -> next cycle shows all outputs 0, o_ready=1, S_STATIC, and duties 0.

Source files
------------

// File: rtl/rgb_led_ctrl_if.sv
// rtl/rgb_led_ctrl_if.sv - register write port and LED/frame outputs of rgb_led_ctrl
interface rgb_led_ctrl_if;
    logic       i_wr;
    logic [1:0] i_addr;
    logic [7:0] i_data;
    logic       o_ready;
    logic       o_led_r;
    logic       o_led_g;
    logic       o_led_b;
    logic       o_frame;

    modport master (
        output i_wr, i_addr, i_data,
        input  o_ready, o_led_r, o_led_g, o_led_b, o_frame
    );

    modport slave (
        input  i_wr, i_addr, i_data,
        output o_ready, o_led_r, o_led_g, o_led_b, o_frame
    );
endinterface

// File: rtl/rgb_led_ctrl.sv
// rtl/rgb_led_ctrl.sv - 3-channel 8-bit PWM LED driver with static, blink and breathe sequencing
module rgb_led_ctrl #(
    parameter int unsigned PRESCALE     = 187,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input logic         i_clk,
    input logic         i_rst_n,
    rgb_led_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_STATIC,
        S_BLINK_ON,
        S_BLINK_OFF,
        S_RAMP_UP,
        S_RAMP_DOWN
    } state_t;

    localparam logic [15:0] PRESC_LAST   = 16'(PRESCALE - 1);
    localparam logic [7:0]  BLINK_LAST   = 8'(BLINK_FRAMES - 1);
    localparam logic [1:0]  MODE_BLINK   = 2'd1;
    localparam logic [1:0]  MODE_BREATHE = 2'd2;

    logic [15:0] presc;
    logic [7:0]  pwm_cnt;
    logic        tick;
    logic        boundary;
    logic        wr_accept;

    logic [7:0]  shadow_duty [3];
    logic [7:0]  active_duty [3];
    logic [1:0]  shadow_mode;
    logic [1:0]  active_mode;

    state_t      state, state_nxt;
    logic [7:0]  env, env_nxt;
    logic [7:0]  frame_cnt, frame_cnt_nxt;
    logic [7:0]  eff [3];

    assign tick      = (presc == PRESC_LAST);
    assign boundary  = tick && (pwm_cnt == 8'hff);
    assign bus.o_ready = !boundary || !i_rst_n;
    assign wr_accept = bus.i_wr && !boundary;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
        end
    end

    // Writes land in shadow copies; the LED side only sees them at a frame boundary.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int c = 0; c < 3; c++) begin
                shadow_duty[c] <= '0;
                active_duty[c] <= '0;
            end
            shadow_mode <= '0;
            active_mode <= '0;
        end else begin
            if (wr_accept) begin
                for (int c = 0; c < 3; c++) begin
                    if (bus.i_addr == 2'(c)) begin
                        shadow_duty[c] <= bus.i_data;
                    end
                end
                if (bus.i_addr == 2'd3) begin
                    shadow_mode <= (bus.i_data[1:0] == 2'd3) ? 2'd0 : bus.i_data[1:0];
                end
            end
            if (boundary) begin
                for (int c = 0; c < 3; c++) begin
                    active_duty[c] <= shadow_duty[c];
                end
                active_mode <= shadow_mode;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= S_STATIC;
            env       <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            env       <= env_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        env_nxt       = env;
        frame_cnt_nxt = frame_cnt;
        if (boundary) begin
            if (shadow_mode != active_mode) begin
                frame_cnt_nxt = '0;
                env_nxt       = '0;
                case (shadow_mode)
                    MODE_BLINK:   state_nxt = S_BLINK_ON;
                    MODE_BREATHE: state_nxt = S_RAMP_UP;
                    default:      state_nxt = S_STATIC;
                endcase
            end else begin
                case (state)
                    S_BLINK_ON, S_BLINK_OFF: begin
                        if (frame_cnt == BLINK_LAST) begin
                            frame_cnt_nxt = '0;
                            state_nxt     = (state == S_BLINK_ON) ? S_BLINK_OFF : S_BLINK_ON;
                        end else begin
                            frame_cnt_nxt = frame_cnt + 8'd1;
                        end
                    end
                    // Turn around on the frame that reaches the extreme, so env never wraps.
                    S_RAMP_UP: begin
                        env_nxt = env + 8'd1;
                        if (env == 8'd254) begin
                            state_nxt = S_RAMP_DOWN;
                        end
                    end
                    S_RAMP_DOWN: begin
                        env_nxt = env - 8'd1;
                        if (env == 8'd1) begin
                            state_nxt = S_RAMP_UP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            eff[c] = active_duty[c];
            case (state)
                S_BLINK_OFF:            eff[c] = '0;
                S_RAMP_UP, S_RAMP_DOWN: eff[c] = 8'((16'(active_duty[c]) * 16'(env)) >> 8);
                default:                eff[c] = active_duty[c];
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus.o_led_r <= 1'b0;
            bus.o_led_g <= 1'b0;
            bus.o_led_b <= 1'b0;
            bus.o_frame <= 1'b0;
        end else begin
            bus.o_led_r <= eff[0] > pwm_cnt;
            bus.o_led_g <= eff[1] > pwm_cnt;
            bus.o_led_b <= eff[2] > pwm_cnt;
            bus.o_frame <= boundary;
        end
    end

endmodule
